// File: rtl/snes_ctrlr.sv
// Two-pad SNES controller poller with a 4-entry read-only register window.
// Pads are latched and clocked autonomously; snapshots commit atomically once per frame.
module snes_ctrlr #(
  parameter int HALF_CYC  = 150,
  parameter int LATCH_CYC = 600,
  parameter int POLL_CYC  = 833333
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrlr_re,
  input  logic [1:0]  addr_ctrlr,
  output logic [15:0] din_ctrlrs,
  output logic        snes_latch,
  output logic        snes_clk,
  input  logic        snes_data0,
  input  logic        snes_data1
);

  localparam logic [19:0] POLL_LAST  = 20'(POLL_CYC - 1);
  localparam logic [19:0] LATCH_LAST = 20'(LATCH_CYC - 1);
  localparam logic [19:0] HALF_LAST  = 20'(HALF_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    LOW    = 3'd2,
    HIGH   = 3'd3,
    COMMIT = 3'd4
  } state_t;

  state_t      state_r, state_nx;
  logic [19:0] cnt_r, cnt_nx;
  logic [3:0]  bit_r, bit_nx;
  logic        sample_s, commit_s, busy_s;
  logic [1:0]  sync0_r, sync1_r;
  logic [15:0] sr0_r, sr1_r, pad0_r, pad1_r, frame_cnt_r, rd_s;
  logic        upd_r, latch_r, sclk_r;

  // Frame sequencer: next state, phase counter and bit index.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r + 20'd1;
    bit_nx   = bit_r;
    sample_s = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cnt_r == POLL_LAST) begin
          state_nx = LATCH;
          cnt_nx   = 20'd0;
        end else begin
          state_nx = IDLE;
        end
      end
      LATCH: begin
        if (cnt_r == LATCH_LAST) begin
          state_nx = LOW;
          cnt_nx   = 20'd0;
          bit_nx   = 4'd0;
        end else begin
          state_nx = LATCH;
        end
      end
      LOW: begin
        if (cnt_r == HALF_LAST) begin
          sample_s = 1'b1;
          state_nx = HIGH;
          cnt_nx   = 20'd0;
        end else begin
          state_nx = LOW;
        end
      end
      HIGH: begin
        if (cnt_r == HALF_LAST) begin
          cnt_nx = 20'd0;
          if (bit_r == 4'd15) begin
            state_nx = COMMIT;
          end else begin
            bit_nx   = bit_r + 4'd1;
            state_nx = LOW;
          end
        end else begin
          state_nx = HIGH;
        end
      end
      COMMIT: begin
        commit_s = 1'b1;
        state_nx = IDLE;
        cnt_nx   = 20'd0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 20'd0;
        bit_nx   = 4'd0;
      end
    endcase
  end

  // Sequencer state plus pad pins registered from the next state so they never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 20'd0;
      bit_r   <= 4'd0;
      latch_r <= 1'b0;
      sclk_r  <= 1'b1;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      bit_r   <= bit_nx;
      latch_r <= (state_nx == LATCH);
      sclk_r  <= (state_nx != LOW);
    end
  end

  assign snes_latch = latch_r;
  assign snes_clk   = sclk_r;
  assign busy_s     = (state_r != IDLE);

  // Synchronize pad data and shift it in LSB-first (first bit ends at bit 0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync0_r <= 2'b11;
      sync1_r <= 2'b11;
      sr0_r   <= 16'h0000;
      sr1_r   <= 16'h0000;
    end else begin
      sync0_r <= {sync0_r[0], snes_data0};
      sync1_r <= {sync1_r[0], snes_data1};
      if (sample_s) begin
        sr0_r <= {~sync0_r[1], sr0_r[15:1]};
        sr1_r <= {~sync1_r[1], sr1_r[15:1]};
      end
    end
  end

  // Register file; a commit outranks the read-side clear of upd.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pad0_r      <= 16'h0000;
      pad1_r      <= 16'h0000;
      frame_cnt_r <= 16'h0000;
      upd_r       <= 1'b0;
    end else begin
      if (commit_s) begin
        pad0_r      <= sr0_r;
        pad1_r      <= sr1_r;
        frame_cnt_r <= frame_cnt_r + 16'd1;
        upd_r       <= 1'b1;
      end else if (ctrlr_re && (addr_ctrlr == 2'd2)) begin
        upd_r <= 1'b0;
      end
    end
  end

  // Read-side register select.
  always_comb begin
    rd_s = 16'h0000;
    case (addr_ctrlr)
      2'd0:    rd_s = pad0_r;
      2'd1:    rd_s = pad1_r;
      2'd2:    rd_s = {14'd0, upd_r, busy_s};
      2'd3:    rd_s = frame_cnt_r;
      default: rd_s = 16'h0000;
    endcase
  end

  // Read data register, held between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_ctrlrs <= 16'h0000;
    end else if (ctrlr_re) begin
      din_ctrlrs <= rd_s;
    end
  end

endmodule

// File: tb/tb_snes_ctrlr.sv
// Randomized scoreboard bench for snes_ctrlr with behavioural pad and frame-timeline model.
module tb_snes_ctrlr;
  localparam int HALF = 2;
  localparam int LAT  = 4;
  localparam int POLL = 20;
  localparam int PER  = POLL + LAT + 32 * HALF + 1;
  localparam int S0   = POLL + LAT;
  localparam int CPOS = PER - 1;

  logic        clk = 1'b0, rst = 1'b0, ctrlr_re = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [15:0] din;
  logic        latch, sclk, d0, d1;
  logic [15:0] btn0 = 16'h0, btn1 = 16'h0, sh0 = 16'h0, sh1 = 16'h0, lat0 = 16'h0, lat1 = 16'h0;

  int tests = 0, fails = 0;
  int t = 0, mp, wp;
  logic [15:0] m_pad0 = 16'h0, m_pad1 = 16'h0, m_cnt = 16'h0, me, mon_e;
  logic        m_upd = 1'b0, was_re;
  logic [15:0] exp_q[$];

  snes_ctrlr #(.HALF_CYC(HALF), .LATCH_CYC(LAT), .POLL_CYC(POLL)) dut (
    .clk(clk), .rst(rst), .ctrlr_re(ctrlr_re), .addr_ctrlr(addr), .din_ctrlrs(din),
    .snes_latch(latch), .snes_clk(sclk), .snes_data0(d0), .snes_data1(d1)
  );

  initial forever #5 clk = ~clk;

  // Pad model: latch loads the buttons, each rising clock presents the next one.
  assign d0 = ~sh0[0];
  assign d1 = ~sh1[0];
  initial forever begin
    @(posedge sclk or posedge latch);
    #1;
    if (latch) begin
      sh0 = btn0; sh1 = btn1; lat0 = btn0; lat1 = btn1;
    end else begin
      sh0 = {1'b0, sh0[15:1]}; sh1 = {1'b0, sh1[15:1]};
    end
  end

  function automatic bit in_low(int p);
    return (p >= S0) && (p < CPOS) && (((p - S0) % (2 * HALF)) < HALF);
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, t);
    end
  endtask

  // Reference model: frame position from cycle count since reset release.
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      if (ctrlr_re) exp_q.push_back(16'h0000);
      m_pad0 = 16'h0; m_pad1 = 16'h0; m_cnt = 16'h0; m_upd = 1'b0; t = 0;
    end else begin
      mp = t % PER;
      if (ctrlr_re) begin
        case (addr)
          2'd0:    me = m_pad0;
          2'd1:    me = m_pad1;
          2'd2:    me = {14'd0, m_upd, (mp >= POLL) ? 1'b1 : 1'b0};
          default: me = m_cnt;
        endcase
        exp_q.push_back(me);
      end
      if (mp == CPOS) begin
        m_pad0 = lat0; m_pad1 = lat1; m_upd = 1'b1; m_cnt = m_cnt + 16'd1;
      end else if (ctrlr_re && addr == 2'd2) begin
        m_upd = 1'b0;
      end
      t++;
    end
  end

  // Read monitor: one response per strobe, compared against the scoreboard queue.
  initial forever begin
    @(posedge clk);
    was_re = ctrlr_re;
    #1;
    if (was_re) begin
      if (exp_q.size() == 0) begin
        check("read_q_empty", 16'd1, 16'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("read", din, mon_e);
      end
    end
  end

  // Waveform monitor for latch and serial clock.
  initial forever begin
    @(posedge clk);
    #1;
    wp = t % PER;
    check("latch", {15'd0, latch}, {15'd0, (rst && wp >= POLL && wp < S0) ? 1'b1 : 1'b0});
    check("sclk", {15'd0, sclk}, {15'd0, (rst && in_low(wp)) ? 1'b0 : 1'b1});
  end

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    @(negedge clk);
    while ((t % PER) != p && n < 2 * PER) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2 * PER) check("wait_timeout", 16'd1, 16'd0);
  endtask

  task automatic rd(input logic [1:0] a);
    ctrlr_re = 1'b1;
    addr = a;
    @(negedge clk);
    ctrlr_re = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    for (int a = 0; a < 4; a++) rd(2'(a));
    btn0 = 16'h0801; btn1 = 16'h0000;
    rst = 1'b1;
    wait_pos(S0 + 2 * HALF);
    rd(2'd2);
    wait_pos(CPOS);
    rd(2'd2);
    rd(2'd2);
    rd(2'd0);
    rd(2'd1);
    rd(2'd2);
    btn0 = 16'($urandom); btn1 = 16'($urandom);
    wait_pos(CPOS);
    rd(2'd0);
    rd(2'd0);
    rd(2'd1);
    btn0 = 16'($urandom); btn1 = 16'($urandom);
    wait_pos(CPOS);
    wait_pos(5);
    rd(2'd3);
    for (int f = 0; f < 6; f++) begin
      wait_pos(1);
      btn0 = 16'($urandom); btn1 = 16'($urandom);
      for (int k = 0; k < PER; k++) begin
        ctrlr_re = ($urandom_range(2, 0) == 0);
        addr = 2'($urandom_range(3, 0));
        @(negedge clk);
      end
      ctrlr_re = 1'b0;
    end
    btn0 = 16'($urandom); btn1 = 16'($urandom);
    wait_pos(S0 + 7 * 2 * HALF + HALF);
    rst = 1'b0;
    #1;
    check("rst_latch", {15'd0, latch}, 16'h0000);
    check("rst_sclk", {15'd0, sclk}, 16'h0001);
    check("rst_din", din, 16'h0000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    rd(2'd0);
    rd(2'd3);
    wait_pos(CPOS);
    wait_pos(2);
    rd(2'd0);
    rd(2'd1);
    wait_pos(3);
    force dut.frame_cnt_r = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_r;
    rd(2'd3);
    wait_pos(CPOS);
    wait_pos(2);
    rd(2'd3);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) check("read_q_leftover", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
